log_reader: RTL and testbench



---
 rtl/log_reader_if.sv | 29 ++
 rtl/log_reader.sv | 131 +++++++++++++
 tb/tb_log_reader.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/log_reader_if.sv
// log_reader_if -- log memory read bus and outgoing byte stream of log_reader.
//   o_read_log          : single-cycle request putting the logger in read mode
//   o_addr_log_to_mem   : log read address
//   i_data_log_from_mem : log word {bank_b[15:0], bank_a[15:0]}
//   o_byte/o_byte_valid : outgoing byte and its valid flag
//   i_byte_ready        : downstream accepts the byte on this edge
// master = log_reader side, slave = logger memory / byte consumer side.
`timescale 1ns/1ps
interface log_reader_if #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int LOG_DATA_WIDTH  = 32
);
  logic                       o_read_log;
  logic [BRAM_ADDR_WIDTH-1:0] o_addr_log_to_mem;
  logic [LOG_DATA_WIDTH-1:0]  i_data_log_from_mem;
  logic [7:0]                 o_byte;
  logic                       o_byte_valid;
  logic                       i_byte_ready;

  modport master (
    output o_read_log, o_addr_log_to_mem, o_byte, o_byte_valid,
    input  i_data_log_from_mem, i_byte_ready
  );

  modport slave (
    input  o_read_log, o_addr_log_to_mem, o_byte, o_byte_valid,
    output i_data_log_from_mem, i_byte_ready
  );
endinterface

// File: rtl/log_reader.sv
// log_reader -- dumps a full log capture as a byte stream, MSB first per word.
// Ports:
//   clk          : system clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_start_dump : single-cycle dump request (ignored while busy)
//   i_abort      : cancels a dump in progress, no done/error pulse
//   i_mem_full   : logger holds a complete capture
//   o_busy       : high in every state except IDLE
//   o_done       : single-cycle pulse after the last byte is accepted
//   o_error      : single-cycle pulse on a refused or broken dump
//   bus          : log memory read bus + byte stream (log_reader_if.master)
//
// state | meaning
// IDLE  | waiting for i_start_dump, address held at 0
// ARM   | o_read_log pulse, address cleared to 0
// FETCH | wait READ_LAT cycles for memory data, then capture the word
// SEND  | present 4 bytes MSB first, one per accepted handshake
// NEXT  | advance address, or finish after the last word
// DONE  | o_done pulse
`timescale 1ns/1ps
module log_reader #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int LOG_DATA_WIDTH  = 32,
  parameter int READ_LAT        = 2
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_start_dump,
  input  logic i_abort,
  input  logic i_mem_full,
  output logic o_busy,
  output logic o_done,
  output logic o_error,
  log_reader_if.master bus
);

  typedef enum logic [2:0] {IDLE, ARM, FETCH, SEND, NEXT, DONE} state_t;

  state_t                     state, state_next;
  logic [BRAM_ADDR_WIDTH-1:0] addr;
  logic [LOG_DATA_WIDTH-1:0]  shreg;
  logic [2:0]                 wait_cnt;
  logic [1:0]                 byte_idx;
  logic                       err_q;
  logic                       err_set;
  logic                       xfer;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    xfer       = (state == SEND) && bus.i_byte_ready;
    if (state != IDLE && i_abort) begin
      // abort wins over a simultaneous loss of the capture
      state_next = IDLE;
    end else if ((state == FETCH || state == SEND || state == NEXT) && !i_mem_full) begin
      state_next = IDLE;
      err_set    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_start_dump) begin
            if (i_mem_full) state_next = ARM;
            else            err_set    = 1'b1;
          end
        end
        ARM:   state_next = FETCH;
        FETCH: if (wait_cnt == 3'd0) state_next = SEND;
        SEND:  if (xfer && byte_idx == 2'd3) state_next = NEXT;
        NEXT:  state_next = (addr == {BRAM_ADDR_WIDTH{1'b1}}) ? DONE : FETCH;
        DONE:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr     <= '0;
      shreg    <= '0;
      wait_cnt <= 3'd0;
      byte_idx <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_set;
      if (state_next == IDLE) begin
        addr <= '0;
      end else begin
        case (state)
          ARM: begin
            addr     <= '0;
            wait_cnt <= 3'(READ_LAT);
          end
          FETCH: begin
            if (wait_cnt != 3'd0) begin
              wait_cnt <= wait_cnt - 3'd1;
            end else begin
              shreg    <= bus.i_data_log_from_mem;
              byte_idx <= 2'd0;
            end
          end
          SEND: begin
            if (xfer) begin
              shreg    <= shreg << 8;
              byte_idx <= byte_idx + 2'd1;
            end
          end
          NEXT: begin
            // the last address rolls over to 0 on its own
            addr     <= addr + BRAM_ADDR_WIDTH'(1);
            wait_cnt <= 3'(READ_LAT);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_read_log        = (state == ARM);
  assign bus.o_addr_log_to_mem = addr;
  assign bus.o_byte_valid      = (state == SEND);
  assign bus.o_byte            = shreg[LOG_DATA_WIDTH-1 -: 8];
  assign o_busy                = (state != IDLE);
  assign o_done                = (state == DONE) && !i_abort;
  assign o_error               = err_q;

endmodule

// File: tb/tb_log_reader.sv
`timescale 1ns/1ps
module tb_log_reader;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic i_rst_n = 1'b1;
  logic i_start_dump = 1'b0;
  logic i_abort = 1'b0;
  logic i_mem_full = 1'b0;
  logic o_busy, o_done, o_error;

  log_reader_if #(.BRAM_ADDR_WIDTH(AW), .LOG_DATA_WIDTH(DW)) bus ();

  log_reader #(.BRAM_ADDR_WIDTH(AW), .LOG_DATA_WIDTH(DW), .READ_LAT(RL)) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_start_dump (i_start_dump),
    .i_abort      (i_abort),
    .i_mem_full   (i_mem_full),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // memory model: word[n] = A0B0C000 + n, data valid RL edges after the address
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'hA0B0C000 + 32'(a);
  endfunction

  logic [DW-1:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= mem_word(bus.o_addr_log_to_mem);
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.i_data_log_from_mem = pipe[RL-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor state
  logic [7:0] got [$];
  int  cyc = 0, cnt_read_log, cnt_done, cnt_error, cnt_busy;
  int  last_xfer_cyc, done_cyc, stab_viol;
  bit  rnd_ready = 0;
  logic prev_hold, prev_abort;
  logic [7:0] prev_byte;

  task automatic clear_mon();
    got.delete();
    cnt_read_log = 0; cnt_done = 0; cnt_error = 0; cnt_busy = 0;
    last_xfer_cyc = 0; done_cyc = 0; stab_viol = 0;
    prev_hold = 1'b0; prev_abort = 1'b0; prev_byte = 8'h00;
  endtask

  task automatic advance();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // sample the current cycle (inputs already applied), then move one cycle on
  task automatic tick();
    if (rnd_ready) bus.i_byte_ready = ($urandom_range(0, 99) < 30);
    #0;
    if (prev_hold && !prev_abort)
      if (!bus.o_byte_valid || bus.o_byte !== prev_byte) stab_viol++;
    if (bus.o_byte_valid && bus.i_byte_ready) begin
      got.push_back(bus.o_byte);
      last_xfer_cyc = cyc;
    end
    if (bus.o_read_log) cnt_read_log++;
    if (o_done) begin cnt_done++; done_cyc = cyc; end
    if (o_error) cnt_error++;
    if (o_busy) cnt_busy++;
    prev_hold  = bus.o_byte_valid && !bus.i_byte_ready;
    prev_byte  = bus.o_byte;
    prev_abort = i_abort;
    cyc++;
    advance();
  endtask

  task automatic start_dump();
    i_start_dump = 1'b1;
    tick();
    i_start_dump = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string name);
    for (int g = 0; g < 1000 && got.size() < n; g++) tick();
    check(name, 64'(got.size() >= n), 64'd1);
  endtask

  task automatic run_dump(input bit rnd);
    clear_mon();
    rnd_ready = rnd;
    if (!rnd) bus.i_byte_ready = 1'b1;
    start_dump();
    for (int g = 0; g < 3000 && o_busy; g++) tick();
    rnd_ready = 0;
    check("dump_terminates", 64'(o_busy), 64'd0);
  endtask

  task automatic check_dump(input string tag);
    int bad;
    logic [31:0] first, last, w;
    bad = 0; first = 32'h0; last = 32'h0;
    for (int i = 0; i < got.size() && i < 64; i++) begin
      w = mem_word(AW'(i / 4));
      if (got[i] !== w[31 - 8*(i % 4) -: 8]) bad++;
    end
    if (got.size() >= 4)  first = {got[0], got[1], got[2], got[3]};
    if (got.size() >= 64) last  = {got[60], got[61], got[62], got[63]};
    check({tag, "_count"},     64'(got.size()), 64'd64);
    check({tag, "_bad_bytes"}, 64'(bad), 64'd0);
    check({tag, "_first"},     64'(first), 64'hA0B0C000);
    check({tag, "_last"},      64'(last), 64'hA0B0C00F);
    check({tag, "_read_log"},  64'(cnt_read_log), 64'd1);
    check({tag, "_done"},      64'(cnt_done), 64'd1);
    check({tag, "_error"},     64'(cnt_error), 64'd0);
    // handshake cycle, then NEXT, then DONE
    check({tag, "_done_lat"},  64'(done_cyc - last_xfer_cyc), 64'd2);
  endtask

  typedef struct packed {
    logic       start, full, abort, ready;
    logic       busy, rl, valid;
    logic [7:0] byt;
    logic [3:0] addr;
    logic       err, done;
  } vec_t;

  vec_t vecs [20];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          st  fu  ab  rd  busy rl  val byte   addr   err done
    vecs[0]  = '{0,  1,  0,  0,  0,  0,  0,  8'h00, 4'd0,  0,  0}; // IDLE
    vecs[1]  = '{1,  0,  0,  0,  0,  0,  0,  8'h00, 4'd0,  0,  0}; // refused start
    vecs[2]  = '{0,  0,  0,  0,  0,  0,  0,  8'h00, 4'd0,  1,  0}; // error pulse
    vecs[3]  = '{0,  1,  0,  0,  0,  0,  0,  8'h00, 4'd0,  0,  0};
    vecs[4]  = '{1,  1,  0,  0,  0,  0,  0,  8'h00, 4'd0,  0,  0}; // accepted start
    vecs[5]  = '{0,  1,  0,  0,  1,  1,  0,  8'h00, 4'd0,  0,  0}; // ARM
    vecs[6]  = '{1,  1,  0,  1,  1,  0,  0,  8'h00, 4'd0,  0,  0}; // FETCH, start ignored
    vecs[7]  = '{0,  1,  0,  0,  1,  0,  0,  8'h00, 4'd0,  0,  0}; // FETCH
    vecs[8]  = '{0,  1,  0,  0,  1,  0,  0,  8'h00, 4'd0,  0,  0}; // FETCH capture
    vecs[9]  = '{0,  1,  0,  0,  1,  0,  1,  8'hA0, 4'd0,  0,  0}; // SEND stall
    vecs[10] = '{0,  1,  0,  1,  1,  0,  1,  8'hA0, 4'd0,  0,  0};
    vecs[11] = '{0,  1,  0,  1,  1,  0,  1,  8'hB0, 4'd0,  0,  0};
    vecs[12] = '{0,  1,  0,  0,  1,  0,  1,  8'hC0, 4'd0,  0,  0}; // stall
    vecs[13] = '{0,  1,  0,  1,  1,  0,  1,  8'hC0, 4'd0,  0,  0};
    vecs[14] = '{0,  1,  0,  1,  1,  0,  1,  8'h00, 4'd0,  0,  0}; // 4th byte
    vecs[15] = '{0,  1,  0,  0,  1,  0,  0,  8'h00, 4'd0,  0,  0}; // NEXT
    vecs[16] = '{0,  1,  0,  0,  1,  0,  0,  8'h00, 4'd1,  0,  0}; // FETCH word 1
    vecs[17] = '{0,  1,  1,  0,  1,  0,  0,  8'h00, 4'd1,  0,  0}; // abort
    vecs[18] = '{0,  1,  0,  0,  0,  0,  0,  8'h00, 4'd0,  0,  0}; // IDLE
    vecs[19] = '{0,  1,  0,  0,  0,  0,  0,  8'h00, 4'd0,  0,  0};

    bus.i_byte_ready = 1'b0;
    clear_mon();

    // asynchronous reset before any clock edge
    #1 i_rst_n = 1'b0;
    #2;
    check("reset_outputs",
          64'({o_busy, o_done, o_error, bus.o_read_log, bus.o_byte_valid, bus.o_byte, bus.o_addr_log_to_mem}),
          64'd0);
    #9 i_rst_n = 1'b1;
    @(negedge clk); #1;
    advance();

    for (int i = 0; i < 20; i++) begin
      i_start_dump     = vecs[i].start;
      i_mem_full       = vecs[i].full;
      i_abort          = vecs[i].abort;
      bus.i_byte_ready = vecs[i].ready;
      #0;
      check($sformatf("vec%0d_ctl", i),
            64'({o_busy, bus.o_read_log, bus.o_byte_valid, bus.o_addr_log_to_mem, o_error, o_done}),
            64'({vecs[i].busy, vecs[i].rl, vecs[i].valid, vecs[i].addr, vecs[i].err, vecs[i].done}));
      if (vecs[i].valid)
        check($sformatf("vec%0d_byte", i), 64'(bus.o_byte), 64'(vecs[i].byt));
      advance();
    end
    i_start_dump = 1'b0; i_abort = 1'b0; i_mem_full = 1'b1; bus.i_byte_ready = 1'b0;

    // full dump, ready tied high
    run_dump(0);
    check_dump("full");

    // 30% ready duty
    run_dump(1);
    check_dump("rand");
    check("rand_stable", 64'(stab_viol), 64'd0);

    // refused dump
    clear_mon();
    i_mem_full = 1'b0;
    start_dump();
    for (int k = 0; k < 4; k++) tick();
    check("refuse_error", 64'(cnt_error), 64'd1);
    check("refuse_busy",  64'(cnt_busy), 64'd0);
    check("refuse_rdlog", 64'(cnt_read_log), 64'd0);
    i_mem_full = 1'b1;

    // abort after byte 9, no handshake on the abort cycle
    clear_mon();
    bus.i_byte_ready = 1'b1;
    start_dump();
    wait_bytes(9, "abort9_reach");
    bus.i_byte_ready = 1'b0;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort9_idle", 64'({o_busy, bus.o_byte_valid, bus.o_addr_log_to_mem}), 64'd0);
    bus.i_byte_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check("abort9_bytes", 64'(got.size()), 64'd9);
    check("abort9_flags", 64'({cnt_done[7:0], cnt_error[7:0]}), 64'd0);

    // abort on the same edge as a handshake: that byte counts, nothing more
    clear_mon();
    start_dump();
    wait_bytes(5, "abort_hs_reach");
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_hs_idle", 64'(o_busy), 64'd0);
    for (int k = 0; k < 6; k++) tick();
    check("abort_hs_bytes", 64'(got.size()), 64'd6);
    check("abort_hs_flags", 64'({cnt_done[7:0], cnt_error[7:0]}), 64'd0);

    // capture lost after word 4, before word 5 is fetched
    clear_mon();
    start_dump();
    wait_bytes(20, "lost_reach");
    i_mem_full = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("lost_error", 64'(cnt_error), 64'd1);
    check("lost_idle",  64'({o_busy, bus.o_addr_log_to_mem}), 64'd0);
    check("lost_bytes", 64'(got.size()), 64'd20);
    check("lost_done",  64'(cnt_done), 64'd0);
    i_mem_full = 1'b1;

    // reset pulse mid-SEND
    clear_mon();
    start_dump();
    wait_bytes(6, "rst_reach");
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_outputs",
          64'({o_busy, o_done, o_error, bus.o_read_log, bus.o_byte_valid, bus.o_byte, bus.o_addr_log_to_mem}),
          64'd0);
    #2 i_rst_n = 1'b1;
    @(negedge clk); #1;
    clear_mon();
    for (int k = 0; k < 5; k++) tick();
    check("rst_stays_idle", 64'({cnt_busy[7:0], cnt_done[7:0], cnt_error[7:0]}), 64'd0);
    run_dump(0);
    check_dump("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
